// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - wide add/subtract sequenced one N-bit slice per cycle over an external shared adder
module wide_add_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout,
    output logic               out_of,
    output logic               busy,
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    output logic               add_cin,
    input  logic [N-1:0]       add_s,
    input  logic               add_cout
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [WORDS-1:0][N-1:0]    r_a;
    logic [WORDS-1:0][N-1:0]    r_b;
    logic [WORDS-1:0][N-1:0]    r_sum;
    logic [IW-1:0]              r_idx;
    logic                       r_carry;
    logic                       r_cout;
    logic                       r_of;
    logic                       w_last;
    logic                       w_a_msb;
    logic                       w_b_msb;

    assign w_last  = (r_idx == IDX_LAST);
    assign w_a_msb = r_a[WORDS-1][N-1];
    // r_b already holds ~B for subtract, so this sign compare is the signed-overflow rule for both ops
    assign w_b_msb = r_b[WORDS-1][N-1];

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_of    = r_of;

    always_comb begin
        w_next  = r_state;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                add_a   = r_a[r_idx];
                add_b   = r_b[r_idx];
                add_cin = r_carry;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= add_s;
                    r_carry      <= add_cout;
                    r_idx        <= r_idx + IDX_ONE;
                    if (w_last) begin
                        r_cout <= add_cout;
                        r_of   <= (add_s[N-1] ^ w_a_msb) & ~(w_a_msb ^ w_b_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - vector table, random ops against an arithmetic model, and handshake/reset corner sequences
module tb_wide_add_sequencer;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_of;
    logic         busy;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_s;
    logic         add_cout;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_of   (out_of),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // The shared slice adder that lives outside the block
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Signed/unsigned meaning of the result, not the slice mechanics
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] s, output logic c, output logic o);
        logic signed [W:0] sres;
        if (sub) begin
            s    = a - b;
            c    = (a >= b);
            sres = $signed({a[W-1], a}) - $signed({b[W-1], b});
        end else begin
            {c, s} = {1'b0, a} + {1'b0, b};
            sres   = $signed({a[W-1], a}) + $signed({b[W-1], b});
        end
        o = (sres[W] != sres[W-1]);
    endfunction

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo, input bit hold);
        int lat;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom, $urandom, $urandom};
        in_b     = ~b;
        in_sub   = ~sub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, W'(lat), W'(WORDS));
        chk({nm, ".sum"}, out_sum, es);
        chk({nm, ".cout"}, W'(out_cout), W'(ec));
        chk({nm, ".of"}, W'(out_of), W'(eo));
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    vec_t         vecs[6];
    logic [W-1:0] ra, rb, es;
    logic         rs, ec, eo;
    int           t1, t2;
    bit           seen;

    initial begin
        vecs[0] = '{"carry_prop", {32'h0, {96{1'b1}}}, 128'd1, 1'b0, {32'h1, 96'h0}, 1'b0, 1'b0};
        vecs[1] = '{"sub_underflow", 128'd0, 128'd1, 1'b1, {W{1'b1}}, 1'b0, 1'b0};
        vecs[2] = '{"add_ovf", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'h0}, 1'b0, 1'b1};
        vecs[3] = '{"sub_ovf", {1'b1, 127'h0}, 128'd1, 1'b1, {1'b0, {127{1'b1}}}, 1'b1, 1'b1};
        vecs[4] = '{"full_carry", {W{1'b1}}, {W{1'b1}}, 1'b0, {{127{1'b1}}, 1'b0}, 1'b1, 1'b0};
        vecs[5] = '{"sub_equal", 128'h1234, 128'h1234, 1'b1, 128'h0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset.in_ready", W'(in_ready), W'(1));
        chk("reset.out_valid", W'(out_valid), W'(0));
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.out_sum", out_sum, '0);
        chk("reset.add_bus", W'({add_a, add_b, add_cin}), '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rs = $urandom_range(0, 1);
            if (i % 4 == 1) ra[W-2:N] = '1;
            if (i % 4 == 2) rb = ~ra;
            if (i % 4 == 3) rb = ra;
            model(ra, rb, rs, es, ec, eo);
            run_op($sformatf("rand%0d", i), ra, rb, rs, es, ec, eo, 1'b0);
        end

        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        model(ra, rb, 1'b1, es, ec, eo);
        run_op("bp", ra, rb, 1'b1, es, ec, eo, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0];
            in_a     = {$urandom, $urandom, $urandom, $urandom};
            chk("bp.out_valid", W'(out_valid), W'(1));
            chk("bp.in_ready", W'(in_ready), W'(0));
            chk("bp.sum_hold", out_sum, es);
            chk("bp.flags_hold", W'({out_cout, out_of}), W'({ec, eo}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.release_valid", W'(out_valid), W'(0));
        chk("bp.release_ready", W'(in_ready), W'(1));

        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        model(ra, rb, 1'b0, es, ec, eo);
        in_a     = ra;
        in_b     = rb;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        t1 = cyc;
        t2 = t1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                chk("b2b.sum", out_sum, es);
            end
            if (in_ready) begin
                t2 = cyc;
                in_valid = 1'b0;
                break;
            end
        end
        chk("b2b.seen_valid", W'(seen), W'(1));
        chk("b2b.period", W'(t2 - t1), W'(WORDS + 2));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        in_a     = {W{1'b1}};
        in_b     = {W{1'b1}};
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run.in_ready", W'(in_ready), W'(1));
        chk("rst_run.busy", W'(busy), W'(0));
        chk("rst_run.out_valid", W'(out_valid), W'(0));
        chk("rst_run.out_sum", out_sum, '0);
        chk("rst_run.flags", W'({out_cout, out_of}), '0);
        chk("rst_run.add_bus", W'({add_a, add_b, add_cin}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 128'd5, 128'd3, 1'b0, 128'd8, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
